// File: rtl/booth_product_accumulator_if.sv
// ---------------------------------------------------------------------------
// booth_product_accumulator_if
//
// Purpose: bundles the product-side and sum-side handshakes of the Booth
// product accumulator into one interface. The producer/consumer environment
// uses the master modport and the accumulator itself uses the slave modport.
//
// Parameters:
//   N      operand width of the upstream multiplier (product is 2N bits)
//   ACC_W  signed accumulator width, must be at least 2N+1
//
// Signals:
//   acc_clear   master->slave  synchronous abort/clear of the current batch
//   prod_valid  master->slave  product is valid this cycle
//   prod_ready  slave->master  accumulator can take a product
//   product     master->slave  signed 2N-bit product
//   prod_last   master->slave  accepted beat closes the batch
//   acc_valid   slave->master  acc_out holds a finished batch sum
//   acc_ready   master->slave  consumer takes acc_out
//   acc_out     slave->master  signed batch sum
//   acc_count   slave->master  beats in the batch, saturating at 16'hFFFF
//   acc_ovf     slave->master  sticky signed-overflow flag for the batch
// ---------------------------------------------------------------------------
interface booth_product_accumulator_if #(
  parameter int N     = 64,
  parameter int ACC_W = 2*N+8
);

  logic             acc_clear;
  logic             prod_valid;
  logic             prod_ready;
  logic [2*N-1:0]   product;
  logic             prod_last;
  logic             acc_valid;
  logic             acc_ready;
  logic [ACC_W-1:0] acc_out;
  logic [15:0]      acc_count;
  logic             acc_ovf;

  modport master (
    output acc_clear,
    output prod_valid,
    output product,
    output prod_last,
    output acc_ready,
    input  prod_ready,
    input  acc_valid,
    input  acc_out,
    input  acc_count,
    input  acc_ovf
  );

  modport slave (
    input  acc_clear,
    input  prod_valid,
    input  product,
    input  prod_last,
    input  acc_ready,
    output prod_ready,
    output acc_valid,
    output acc_out,
    output acc_count,
    output acc_ovf
  );

endinterface

// File: rtl/booth_product_accumulator.sv
// ---------------------------------------------------------------------------
// booth_product_accumulator
//
// Purpose: sums a batch of signed 2N-bit Booth products into a wider signed
// accumulator (multiply-accumulate / dot-product back end). Products arrive
// one per beat over a valid/ready handshake; the beat flagged prod_last
// closes the batch, after which the sum, beat count and overflow flag are
// held on the output side until the consumer accepts them.
//
// Ports:
//   clk    sole clock, rising edge
//   reset  asynchronous, active-high; returns to IDLE with all sums cleared
//   bus    booth_product_accumulator_if.slave (see interface file for signals)
//
// Parameters:
//   N      operand width of the upstream multiplier (product is 2N bits)
//   ACC_W  signed accumulator width; must be at least 2N+1 so that a first
//          beat can never overflow
//
// Build option:
//   BOOTH_ACC_SATURATE_EN  when defined, an overflowing add clamps the
//                          accumulator to the most positive / most negative
//                          value; otherwise the accumulator wraps modulo
//                          2^ACC_W. acc_ovf behaves the same either way.
// ---------------------------------------------------------------------------
module booth_product_accumulator #(
  parameter int N     = 64,
  parameter int ACC_W = 2*N+8
) (
  input logic clk,
  input logic reset,
  booth_product_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  state_t           state_q;
  logic [ACC_W-1:0] accSum_q;
  logic [ACC_W-1:0] accSum_d;
  logic [15:0]      beatCount_q;
  logic [15:0]      beatCount_d;
  logic             accOvf_q;
  logic             accValid_q;

  logic [ACC_W-1:0] prodExt;
  logic [ACC_W-1:0] rawSum;
  logic             addOvf;
  logic             beatAccept;

  // The product is two's complement, so widening replicates its sign bit.
  assign prodExt = {{(ACC_W-2*N){bus.product[2*N-1]}}, bus.product};

  // Ready is the only output with a combinational path: a clear in the same
  // cycle must refuse the beat so that nothing leaks into the aborted batch.
  assign bus.prod_ready = (state_q != HOLD) && !bus.acc_clear;
  assign beatAccept     = bus.prod_valid && bus.prod_ready;

`ifdef BOOTH_ACC_SATURATE_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  // Next accumulator value for a continuing beat. Signed overflow is seen
  // when both addends share a sign and the result sign differs; the sign of
  // the running sum then tells which rail to clamp to in the saturating
  // build. The beat count simply stops at its all-ones value.
  always_comb begin
    rawSum = accSum_q + prodExt;
    addOvf = (accSum_q[ACC_W-1] == prodExt[ACC_W-1]) &&
             (rawSum[ACC_W-1] != accSum_q[ACC_W-1]);
`ifdef BOOTH_ACC_SATURATE_EN
    if (addOvf) begin
      accSum_d = accSum_q[ACC_W-1] ? ACC_MIN : ACC_MAX;
    end else begin
      accSum_d = rawSum;
    end
`else
    accSum_d = rawSum;
`endif
    beatCount_d = (beatCount_q == 16'hFFFF) ? beatCount_q : beatCount_q + 16'd1;
  end

  // Batch controller. IDLE waits for a first beat, which loads the sum
  // rather than adding to it so that the previous batch's result can stay
  // visible until then. ACCUM adds each accepted beat. HOLD presents the
  // result until acc_ready. A clear aborts from any state on the next edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      accSum_q    <= '0;
      beatCount_q <= '0;
      accOvf_q    <= 1'b0;
      accValid_q  <= 1'b0;
    end else if (bus.acc_clear) begin
      state_q     <= IDLE;
      accSum_q    <= '0;
      beatCount_q <= '0;
      accOvf_q    <= 1'b0;
      accValid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (beatAccept) begin
            accSum_q    <= prodExt;
            beatCount_q <= 16'd1;
            accOvf_q    <= 1'b0;
            if (bus.prod_last) begin
              state_q    <= HOLD;
              accValid_q <= 1'b1;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (beatAccept) begin
            accSum_q    <= accSum_d;
            beatCount_q <= beatCount_d;
            accOvf_q    <= accOvf_q | addOvf;
            if (bus.prod_last) begin
              state_q    <= HOLD;
              accValid_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.acc_ready) begin
            state_q    <= IDLE;
            accValid_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          accValid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.acc_valid = accValid_q;
  assign bus.acc_out   = accSum_q;
  assign bus.acc_count = beatCount_q;
  assign bus.acc_ovf   = accOvf_q;

endmodule

// File: tb/tb_booth_product_accumulator.sv
// ---------------------------------------------------------------------------
// tb_booth_product_accumulator
//
// Purpose: drives two accumulators in lockstep with identical 16-bit signed
// products: a wide one (N=64, ACC_W=136) that never overflows and a narrow
// one (N=8, ACC_W=17) that overflows readily. A batch-level reference model
// keeps the accepted beats of the current batch in a queue and folds them
// with plain arithmetic for each accumulator width.
// ---------------------------------------------------------------------------
module tb_booth_product_accumulator;

  logic clock = 1'b0;
  logic reset;

  // Free-running clock; stimulus changes on the falling edge.
  always #5 clock = ~clock;

  booth_product_accumulator_if #(.N(64), .ACC_W(136)) bus64 ();
  booth_product_accumulator_if #(.N(8),  .ACC_W(17))  bus8 ();

  booth_product_accumulator #(.N(64), .ACC_W(136)) dut64 (
    .clk   (clock),
    .reset (reset),
    .bus   (bus64)
  );

  booth_product_accumulator #(.N(8), .ACC_W(17)) dut8 (
    .clk   (clock),
    .reset (reset),
    .bus   (bus8)
  );

  int passCount  = 0;
  int checkCount = 0;

  logic signed [159:0] beats[$];
  bit                  batchOpen = 1'b0;
  bit                  holding   = 1'b0;

  bit                  rndValid;
  bit                  rndLast;
  bit                  rndReady;
  bit                  rndClear;
  int                  rndProd;

  // Single comparison point: counts, and reports any mismatch.
  task automatic checkOutput(input string tag, input logic signed [159:0] observed,
                             input logic signed [159:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Reference sum of the current batch at accumulator width w: first beat
  // loads, later beats add; an out-of-range result flags overflow and is
  // either wrapped by 2^w or clamped to the nearest rail.
  function automatic void foldBatch(input int w, output logic signed [159:0] sum,
                                    output logic ovf);
    logic signed [159:0] span;
    logic signed [159:0] maxV;
    logic signed [159:0] minV;
    logic signed [159:0] r;
    span = 160'sd1 <<< w;
    maxV = (span >>> 1) - 160'sd1;
    minV = -(span >>> 1);
    sum  = '0;
    ovf  = 1'b0;
    foreach (beats[i]) begin
      if (i == 0) begin
        sum = beats[i];
      end else begin
        r = sum + beats[i];
        if (r > maxV) begin
          ovf = 1'b1;
`ifdef BOOTH_ACC_SATURATE_EN
          r = maxV;
`else
          r = r - span;
`endif
        end else if (r < minV) begin
          ovf = 1'b1;
`ifdef BOOTH_ACC_SATURATE_EN
          r = minV;
`else
          r = r + span;
`endif
        end
        sum = r;
      end
    end
  endfunction

  // Compares every registered output of both accumulators with the model.
  task automatic checkState();
    logic signed [159:0] sum8;
    logic signed [159:0] sum64;
    logic                ovf8;
    logic                ovf64;
    int                  cnt;
    foldBatch(17, sum8, ovf8);
    foldBatch(136, sum64, ovf64);
    cnt = (beats.size() > 65535) ? 65535 : beats.size();
    checkOutput("acc_valid8",  bus8.acc_valid,           holding);
    checkOutput("acc_out8",    $signed(bus8.acc_out),    sum8);
    checkOutput("acc_count8",  bus8.acc_count,           cnt);
    checkOutput("acc_ovf8",    bus8.acc_ovf,             ovf8);
    checkOutput("acc_valid64", bus64.acc_valid,          holding);
    checkOutput("acc_out64",   $signed(bus64.acc_out),   sum64);
    checkOutput("acc_count64", bus64.acc_count,          cnt);
    checkOutput("acc_ovf64",   bus64.acc_ovf,            ovf64);
  endtask

  task automatic driveInputs(input bit valid, input int prod, input bit last,
                             input bit ready, input bit clear);
    logic [15:0] p16;
    p16 = prod[15:0];
    bus8.prod_valid  = valid;
    bus8.product     = p16;
    bus8.prod_last   = last;
    bus8.acc_ready   = ready;
    bus8.acc_clear   = clear;
    bus64.prod_valid = valid;
    bus64.product    = {{112{p16[15]}}, p16};
    bus64.prod_last  = last;
    bus64.acc_ready  = ready;
    bus64.acc_clear  = clear;
  endtask

  // One clock cycle: drive, check ready, advance the model, check outputs.
  task automatic applyStimulus(input bit valid, input int prod, input bit last,
                               input bit ready, input bit clear);
    bit                  expReady;
    logic [15:0]         p16;
    logic signed [159:0] pExt;
    driveInputs(valid, prod, last, ready, clear);
    #1;
    expReady = !holding && !clear;
    checkOutput("prod_ready8",  bus8.prod_ready,  expReady);
    checkOutput("prod_ready64", bus64.prod_ready, expReady);
    p16  = prod[15:0];
    pExt = $signed(p16);
    if (clear) begin
      beats.delete();
      batchOpen = 1'b0;
      holding   = 1'b0;
    end else if (holding) begin
      if (ready) holding = 1'b0;
    end else if (valid) begin
      if (!batchOpen) beats.delete();
      beats.push_back(pExt);
      batchOpen = !last;
      holding   = last;
    end
    @(posedge clock);
    @(negedge clock);
    checkState();
  endtask

  initial begin
    reset = 1'b1;
    driveInputs(1'b0, 0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    @(negedge clock);
    checkState();
    checkOutput("reset_prod_ready", bus64.prod_ready, 1);
    reset = 1'b0;

    // Basic batch: 33 - 75 - 12 + 100 = 46
    applyStimulus(1'b1, 33,  1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, -75, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, -12, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 100, 1'b1, 1'b0, 1'b0);
    checkOutput("basic_sum",   $signed(bus64.acc_out), 46);
    checkOutput("basic_count", bus64.acc_count, 4);

    // Backpressure: offered beats are refused while the sum is held
    repeat (5) applyStimulus(1'b1, 77, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_sum", $signed(bus64.acc_out), 46);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
    checkOutput("bp_idle_valid", bus64.acc_valid, 0);
    checkOutput("bp_idle_ready", bus64.prod_ready, 1);

    // Overflow on the 17-bit accumulator: 4 x 16384 = 65536
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16384, (i == 3), 1'b0, 1'b0);
`ifdef BOOTH_ACC_SATURATE_EN
    checkOutput("ovf_sum8", $signed(bus8.acc_out), 65535);
`else
    checkOutput("ovf_sum8", $signed(bus8.acc_out), -65536);
`endif
    checkOutput("ovf_flag8",  bus8.acc_ovf, 1);
    checkOutput("ovf_sum64",  $signed(bus64.acc_out), 65536);
    checkOutput("ovf_flag64", bus64.acc_ovf, 0);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);

    // Bubbles, then a single-beat batch
    applyStimulus(1'b1, 5, 1'b0, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 7, 1'b1, 1'b0, 1'b0);
    checkOutput("bubble_sum",   $signed(bus64.acc_out), 12);
    checkOutput("bubble_count", bus64.acc_count, 2);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, -3, 1'b1, 1'b0, 1'b0);
    checkOutput("single_sum",   $signed(bus64.acc_out), -3);
    checkOutput("single_count", bus64.acc_count, 1);
    checkOutput("single_ovf",   bus64.acc_ovf, 0);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);

    // Clear mid-batch with a simultaneous beat
    applyStimulus(1'b1, 10, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 10, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_clear_sum", $signed(bus64.acc_out), 20);
    applyStimulus(1'b1, 9, 1'b0, 1'b1, 1'b1);
    checkOutput("clear_sum",   $signed(bus64.acc_out), 0);
    checkOutput("clear_count", bus64.acc_count, 0);
    applyStimulus(1'b1, 4, 1'b1, 1'b0, 1'b0);
    checkOutput("post_clear_sum", $signed(bus64.acc_out), 4);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset while holding a result
    applyStimulus(1'b1, 1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2, 1'b1, 1'b0, 1'b0);
    checkOutput("pre_rst_valid", bus64.acc_valid, 1);
    driveInputs(1'b0, 0, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_valid64", bus64.acc_valid, 0);
    checkOutput("rst_sum64",   $signed(bus64.acc_out), 0);
    checkOutput("rst_count64", bus64.acc_count, 0);
    checkOutput("rst_ovf64",   bus64.acc_ovf, 0);
    checkOutput("rst_ready64", bus64.prod_ready, 1);
    checkOutput("rst_valid8",  bus8.acc_valid, 0);
    checkOutput("rst_sum8",    $signed(bus8.acc_out), 0);
    #1 reset = 1'b0;
    beats.delete();
    batchOpen = 1'b0;
    holding   = 1'b0;
    @(negedge clock);
    applyStimulus(1'b1, 6, 1'b1, 1'b0, 1'b0);
    checkOutput("resume_sum", $signed(bus64.acc_out), 6);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);

    // Randomized traffic, including backpressure and occasional clears
    repeat (400) begin
      rndValid = ($urandom_range(0, 9) < 7);
      rndProd  = int'($urandom);
      rndLast  = ($urandom_range(0, 3) == 0);
      rndReady = ($urandom_range(0, 1) == 1);
      rndClear = ($urandom_range(0, 29) == 0);
      applyStimulus(rndValid, rndProd, rndLast, rndReady, rndClear);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
